sreg_8b_universal: RTL and testbench

8-bit universal shift register with synchronous parallel load, serial shift-left with serial input, and hold. It is used as a general parallel/serial converter in datapaths: it captures a parallel word, shifts it out MSB-first, and shifts serial input in at the LSB. All state lives in one 8-bit register that drives both outputs directly.

---
 rtl/sreg_8b_universal.sv | 38 +++
 tb/tb_sreg_8b_universal.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sreg_8b_universal.sv
// 8-bit universal shift register: synchronous parallel load, shift-left with serial-in, hold.
// One register drives both outputs; sout is the MSB of that register.
module sreg_8b_universal (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] pin,
  input  logic       sin,
  output logic [7:0] pout,
  output logic       sout
);

  logic [7:0] reg_q;
  logic [7:0] reg_d;

  // Load takes priority over shift; with neither asserted the register holds.
  always_comb begin
    reg_d = reg_q;
    if (ld) begin
      reg_d = pin;
    end else if (en) begin
      reg_d = {reg_q[6:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign pout = reg_q;
  assign sout = reg_q[7];

endmodule

// File: tb/tb_sreg_8b_universal.sv
// Self-checking bench for sreg_8b_universal: directed scenarios plus a randomized
// run checked against an arithmetic model of the load/shift/hold priority rules.
module tb_sreg_8b_universal;

  logic       clk;
  logic       reset;
  logic       en;
  logic       ld;
  logic [7:0] pin;
  logic       sin;
  logic [7:0] pout;
  logic       sout;

  int unsigned tests;
  int unsigned fails;
  int unsigned mdl;

  sreg_8b_universal dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .ld   (ld),
    .pin  (pin),
    .sin  (sin),
    .pout (pout),
    .sout (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance past the edge, and update the model.
  task automatic cycle(input logic r, input logic l, input logic e,
                       input logic [7:0] p, input logic s);
    reset = r; ld = l; en = e; pin = p; sin = s;
    @(posedge clk);
    #1;
    if (!r)      mdl = 0;
    else if (l)  mdl = p;
    else if (e)  mdl = (mdl * 2 + s) % 256;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
    tests++;
    if (pout !== 8'h00 || sout !== 1'b0) begin
      fails++;
      $display("FAIL reset: pout=%h sout=%b expected pout=00 sout=0", pout, sout);
    end
  endtask

  task automatic test_load_shift();
    logic [7:0] seq_exp [8];
    logic [7:0] sins;
    seq_exp = '{8'hAC, 8'h59, 8'hB3, 8'h66, 8'hCD, 8'h9B, 8'h36, 8'h6D};
    sins = 8'b0110_1101; // applied MSB-first: 0,1,1,0,1,1,0,1
    cycle(1'b1, 1'b1, 1'b0, 8'hD6, 1'b0);
    tests++;
    if (pout !== 8'hD6 || sout !== 1'b1) begin
      fails++;
      $display("FAIL load_D6: pout=%h sout=%b expected pout=d6 sout=1", pout, sout);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'h00, sins[7-i]);
      tests++;
      if (pout !== seq_exp[i] || sout !== seq_exp[i][7]) begin
        fails++;
        $display("FAIL shift_step%0d: pout=%h sout=%b expected pout=%h sout=%b",
                 i, pout, sout, seq_exp[i], seq_exp[i][7]);
      end
    end
  endtask

  task automatic test_shift_out_hold();
    logic [7:0] exp_v;
    cycle(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    exp_v = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      exp_v = exp_v << 1;
      tests++;
      if (pout !== exp_v || sout !== exp_v[7]) begin
        fails++;
        $display("FAIL shiftout%0d: pout=%h sout=%b expected pout=%h sout=%b",
                 i, pout, sout, exp_v, exp_v[7]);
      end
      if (i == 2) begin
        for (int h = 0; h < 3; h++) begin
          cycle(1'b1, 1'b0, 1'b0, 8'h5A, 1'b1);
          tests++;
          if (pout !== exp_v || sout !== exp_v[7]) begin
            fails++;
            $display("FAIL hold%0d: pout=%h sout=%b expected pout=%h sout=%b",
                     h, pout, sout, exp_v, exp_v[7]);
          end
        end
      end
    end
  endtask

  task automatic test_reload_mid_shift();
    cycle(1'b1, 1'b1, 1'b0, 8'hC9, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    tests++;
    if (pout !== 8'h24) begin
      fails++;
      $display("FAIL reload_pre: pout=%h expected 24", pout);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    tests++;
    if (pout !== 8'hFF || sout !== 1'b1) begin
      fails++;
      $display("FAIL reload: pout=%h sout=%b expected pout=ff sout=1", pout, sout);
    end
  endtask

  task automatic test_priority();
    cycle(1'b1, 1'b1, 1'b1, 8'h65, 1'b1);
    tests++;
    if (pout !== 8'h65 || sout !== 1'b0) begin
      fails++;
      $display("FAIL ld_over_en: pout=%h sout=%b expected pout=65 sout=0", pout, sout);
    end
    cycle(1'b1, 1'b0, 1'b0, 8'hAA, 1'b1);
    tests++;
    if (pout !== 8'h65) begin
      fails++;
      $display("FAIL idle_ignores_pin: pout=%h expected 65", pout);
    end
    // load followed immediately by shift operates on the loaded value
    cycle(1'b1, 1'b1, 1'b0, 8'h81, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    tests++;
    if (pout !== 8'h03 || sout !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back: pout=%h sout=%b expected pout=03 sout=0", pout, sout);
    end
  endtask

  task automatic test_reset_mid_op();
    cycle(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    tests++;
    if (pout !== 8'hF8) begin
      fails++;
      $display("FAIL rst_mid_pre: pout=%h expected f8", pout);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, (i == 1), 1'b1, 8'hFF, 1'b1);
      tests++;
      if (pout !== 8'h00 || sout !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid%0d: pout=%h sout=%b expected pout=00 sout=0", i, pout, sout);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
      tests++;
      if (pout !== 8'h00 || sout !== 1'b0) begin
        fails++;
        $display("FAIL rst_release%0d: pout=%h sout=%b expected pout=00 sout=0", i, pout, sout);
      end
    end
  endtask

  task automatic test_random();
    logic       r, l, e, s;
    logic [7:0] p;
    logic [7:0] exp_v;
    for (int i = 0; i < 120; i++) begin
      r = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 3) == 0);
      e = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      p = 8'($urandom);
      cycle(r, l, e, p, s);
      exp_v = 8'(mdl);
      tests++;
      if (pout !== exp_v || sout !== (mdl >= 128)) begin
        fails++;
        $display("FAIL random%0d: pout=%h sout=%b expected pout=%h sout=%b",
                 i, pout, sout, exp_v, (mdl >= 128));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mdl   = 0;
    reset = 1'b0; ld = 1'b0; en = 1'b0; pin = '0; sin = 1'b0;
    test_reset();
    test_load_shift();
    test_shift_out_hold();
    test_reload_mid_shift();
    test_priority();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
